// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage. Owns PC/nPC, issues requests to
//   instruction memory and drives the IF/ID pipeline register. A stall that
//   arrives together with a completed fetch parks the instruction in a 1-entry
//   hold buffer. Branch/jump redirects from ID follow MIPS delay-slot rules.
// Latency: zero-wait memory gives one delivered instruction per cycle. A
//   stalled fetch is delivered from the hold buffer in the first cycle stall=0.
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   stall                   hazard unit: IF/ID must not load this cycle
//   redirect, redirect_target
//                           taken branch/jump resolved in ID
//   imem_req, imem_addr     fetch request; address = PC, held while req is high
//   imem_ready, imem_rdata  response valid, completes the request
//   if_le, if_instruction, if_pc
//                           IF/ID load enable, instruction and its address
//   fetch_count             instructions delivered since reset (wraps)
module instr_fetch_unit #(
  parameter int              PC_W     = 9,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_le,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [PC_W-1:0]    if_pc,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    npc;
  logic [INSTR_W-1:0] hold_buf;
  logic               capture;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and IF/ID-facing outputs. Reset overrides everything so that
  // an in-flight memory response cannot reach IF/ID or the hold buffer.
  always_comb begin
    state_nxt      = state;
    imem_req       = 1'b0;
    if_le          = 1'b0;
    if_instruction = '0;
    capture        = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (!stall) begin
            if_le          = 1'b1;
            if_instruction = imem_rdata;
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          if_le          = 1'b1;
          if_instruction = hold_buf;
          state_nxt      = FETCH;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
    if (reset) begin
      imem_req       = 1'b0;
      if_le          = 1'b0;
      if_instruction = '0;
      capture        = 1'b0;
    end
  end

  assign imem_addr = pc;
  assign if_pc     = reset ? RESET_PC : pc;

  // PC/nPC: a delivery with a redirect means the delivered word is the delay
  // slot, so the next fetch jumps straight to the target. A redirect without
  // a delivery only retargets nPC, so the delay slot at PC is still fetched;
  // repeating it while ID is stalled rewrites the same value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= RESET_PC;
      npc <= RESET_PC + PC_STEP;
    end else if (if_le && redirect) begin
      pc  <= redirect_target;
      npc <= redirect_target + PC_STEP;
    end else if (if_le) begin
      pc  <= npc;
      npc <= npc + PC_STEP;
    end else if (redirect) begin
      npc <= redirect_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_buf <= '0;
    end else if (capture) begin
      hold_buf <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (if_le) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: bench for instr_fetch_unit. Instruction memory returns
//   an address-tagged word unless a test substitutes a fixed word. A reference
//   model tracks PC/nPC, a pending held instruction and the delivery count.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [8:0]  redirect_target;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_le;
  logic [31:0] if_instruction;
  logic [8:0]  if_pc;
  logic [15:0] fetch_count;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .if_le           (if_le),
    .if_instruction  (if_instruction),
    .if_pc           (if_pc),
    .fetch_count     (fetch_count)
  );

  bit          use_force;
  logic [31:0] force_val;

  function automatic logic [31:0] mem_word(logic [8:0] a);
    return {16'hC0DE, 7'd0, a};
  endfunction

  assign imem_rdata = use_force ? force_val : mem_word(imem_addr);

  // Reference model state.
  logic [8:0]  m_pc;
  logic [8:0]  m_npc;
  bit          m_hold;
  logic [31:0] m_buf;
  logic [15:0] m_cnt;

  int total = 0;
  int bad   = 0;

  // Observed bundle; fetch address only matters while a request is raised.
  wire [67:0] obsv = {imem_req, (imem_req ? imem_addr : 9'd0), if_le,
                      if_instruction, if_pc, fetch_count};

  function automatic bit m_delivers();
    if (reset) return 1'b0;
    return m_hold ? !stall : (imem_ready && !stall);
  endfunction

  function automatic logic [67:0] expv();
    logic        req;
    logic        le;
    logic [31:0] ins;
    logic [8:0]  pcv;
    logic [31:0] rd;
    rd  = use_force ? force_val : mem_word(m_pc);
    le  = m_delivers();
    req = !reset && !m_hold;
    ins = le ? (m_hold ? m_buf : rd) : 32'd0;
    pcv = reset ? 9'd0 : m_pc;
    return {req, (req ? m_pc : 9'd0), le, ins, pcv, m_cnt};
  endfunction

  task automatic drive(input bit r, input bit s, input bit rdy, input bit rd,
                       input logic [8:0] t);
    reset           = r;
    stall           = s;
    imem_ready      = rdy;
    redirect        = rd;
    redirect_target = t;
    #2;
  endtask

  // Apply this cycle's rules to the model, then move past the clock edge.
  task automatic advance();
    bit          dlv;
    logic [31:0] rd;
    dlv = m_delivers();
    rd  = use_force ? force_val : mem_word(m_pc);
    if (reset) begin
      m_pc = 9'd0; m_npc = 9'd4; m_hold = 1'b0; m_buf = 32'd0; m_cnt = 16'd0;
    end else begin
      if (!m_hold && imem_ready && stall) begin
        m_hold = 1'b1;
        m_buf  = rd;
      end else if (m_hold && !stall) begin
        m_hold = 1'b0;
      end
      if (dlv) m_cnt = m_cnt + 16'd1;
      if (dlv && redirect) begin
        m_pc  = redirect_target;
        m_npc = redirect_target + 9'd4;
      end else if (dlv) begin
        m_pc  = m_npc;
        m_npc = m_npc + 9'd4;
      end else if (redirect) begin
        m_npc = redirect_target;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [67:0] e;
    drive(1, 0, 1, 0, 9'd0);
    total++;
    if ({imem_req, if_le, if_instruction, if_pc} !== {1'b0, 1'b0, 32'd0, 9'd0}) begin
      $display("FAIL reset_outputs: got req=%0b le=%0b ins=%h pc=%h want 0 0 0 0",
               imem_req, if_le, if_instruction, if_pc);
      bad++;
    end
    advance();
    drive(1, 0, 1, 0, 9'd0);
    e = expv();
    total++;
    if (obsv !== e) begin
      $display("FAIL reset_hold: got %h want %h", obsv, e);
      bad++;
    end
    total++;
    if (fetch_count !== 16'd0) begin
      $display("FAIL reset_count: got %0d want 0", fetch_count);
      bad++;
    end
    advance();
  endtask

  task automatic test_free_run();
    logic [67:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 9'd0);
      e = expv();
      total++;
      if (obsv !== e) begin
        $display("FAIL free_run_%0d: got %h want %h", i, obsv, e);
        bad++;
      end
      total++;
      if (if_le !== 1'b1 || if_pc !== 9'(4 * i)) begin
        $display("FAIL free_run_pc_%0d: got le=%0b pc=%h want 1 %h", i, if_le, if_pc, 9'(4 * i));
        bad++;
      end
      advance();
    end
    drive(0, 0, 0, 0, 9'd0);
    total++;
    if (fetch_count !== 16'd4) begin
      $display("FAIL free_run_count: got %0d want 4", fetch_count);
      bad++;
    end
  endtask

  task automatic test_wait_states();
    logic [67:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, (i == 2), 0, 9'd0);
      e = expv();
      total++;
      if (obsv !== e) begin
        $display("FAIL wait_%0d: got %h want %h", i, obsv, e);
        bad++;
      end
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 9'h010 || if_le !== (i == 2) ||
          (i == 2 && if_pc !== 9'h010)) begin
        $display("FAIL wait_addr_%0d: got req=%0b addr=%h le=%0b pc=%h want 1 010 %0b 010",
                 i, imem_req, imem_addr, if_le, if_pc, (i == 2));
        bad++;
      end
      advance();
    end
  endtask

  task automatic test_stall_hold();
    logic [67:0] e;
    use_force = 1'b1;
    force_val = 32'h24010005;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) use_force = 1'b0;
      drive(0, (i < 3), (i != 4) ? 1'b1 : 1'b0, 0, 9'd0);
      e = expv();
      total++;
      if (obsv !== e) begin
        $display("FAIL stall_hold_%0d: got %h want %h", i, obsv, e);
        bad++;
      end
      if (i == 1 || i == 2) begin
        total++;
        if (imem_req !== 1'b0 || if_le !== 1'b0) begin
          $display("FAIL stall_in_hold_%0d: got req=%0b le=%0b want 0 0", i, imem_req, if_le);
          bad++;
        end
      end
      if (i == 3) begin
        total++;
        if (if_le !== 1'b1 || if_instruction !== 32'h24010005 || if_pc !== 9'h014) begin
          $display("FAIL stall_release: got le=%0b ins=%h pc=%h want 1 24010005 014",
                   if_le, if_instruction, if_pc);
          bad++;
        end
      end
      if (i == 4) begin
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 9'h018) begin
          $display("FAIL stall_next_fetch: got req=%0b addr=%h want 1 018", imem_req, imem_addr);
          bad++;
        end
      end
      advance();
    end
  endtask

  task automatic test_branch_delay_slot();
    logic [67:0] e;
    logic [8:0]  pcs [5];
    bit          rds [5];
    logic [8:0]  tgs [5];
    pcs = '{9'h018, 9'h020, 9'h024, 9'h100, 9'h104};
    rds = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tgs = '{9'h020, 9'h000, 9'h100, 9'h000, 9'h000};
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, rds[i], tgs[i]);
      e = expv();
      total++;
      if (obsv !== e || if_le !== 1'b1 || if_pc !== pcs[i]) begin
        $display("FAIL branch_%0d: got %h pc=%h want %h pc=%h", i, obsv, if_pc, e, pcs[i]);
        bad++;
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [67:0] e;
    logic [8:0]  pcs [8];
    bit          rds [8];
    logic [8:0]  tgs [8];
    pcs = '{9'h108, 9'h1F8, 9'h1FC, 9'h000, 9'h004, 9'h040, 9'h1FC, 9'h000};
    rds = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tgs = '{9'h1F8, 9'h000, 9'h000, 9'h000, 9'h040, 9'h1FC, 9'h000, 9'h000};
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, rds[i], tgs[i]);
      e = expv();
      total++;
      if (obsv !== e || if_le !== 1'b1 || if_pc !== pcs[i]) begin
        $display("FAIL wrap_%0d: got %h pc=%h want %h pc=%h", i, obsv, if_pc, e, pcs[i]);
        bad++;
      end
      advance();
    end
  endtask

  task automatic test_redirect_held();
    logic [67:0] e;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, (i >= 3), (i < 3), 9'h0A0);
      e = expv();
      total++;
      if (obsv !== e) begin
        $display("FAIL redirect_held_%0d: got %h want %h", i, obsv, e);
        bad++;
      end
      if (i >= 3) begin
        total++;
        if (if_pc !== ((i == 3) ? 9'h004 : (i == 4) ? 9'h0A0 : 9'h0A4)) begin
          $display("FAIL redirect_held_pc_%0d: got %h", i, if_pc);
          bad++;
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_in_hold();
    logic [67:0] e;
    drive(0, 1, 1, 0, 9'd0);
    advance();
    drive(1, 1, 1, 0, 9'd0);
    total++;
    if ({imem_req, if_le, if_instruction, if_pc} !== {1'b0, 1'b0, 32'd0, 9'd0}) begin
      $display("FAIL reset_in_hold: got req=%0b le=%0b ins=%h pc=%h want 0 0 0 0",
               imem_req, if_le, if_instruction, if_pc);
      bad++;
    end
    advance();
    drive(0, 1, 1, 0, 9'd0);
    e = expv();
    total++;
    if (obsv !== e || imem_req !== 1'b1 || imem_addr !== 9'd0 || if_le !== 1'b0 ||
        fetch_count !== 16'd0) begin
      $display("FAIL after_reset_in_hold: got %h want %h", obsv, e);
      bad++;
    end
    total++;
    if (dut.hold_buf !== 32'd0) begin
      $display("FAIL hold_buf_cleared: got %h want 0", dut.hold_buf);
      bad++;
    end
    advance();
  endtask

  task automatic test_random();
    logic [67:0] e;
    int          errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0),
            9'($urandom_range(0, 511)));
      e = expv();
      total++;
      if (obsv !== e) begin
        bad++;
        errs++;
        if (errs <= 10) $display("FAIL random_%0d: got %h want %h", i, obsv, e);
      end
      advance();
    end
  endtask

  initial begin
    use_force = 1'b0;
    force_val = 32'd0;
    m_pc = 9'd0; m_npc = 9'd4; m_hold = 1'b0; m_buf = 32'd0; m_cnt = 16'd0;
    drive(1, 0, 0, 0, 9'd0);
    test_reset();
    test_free_run();
    test_wait_states();
    test_stall_hold();
    test_branch_delay_slot();
    test_wrap();
    test_redirect_held();
    test_reset_in_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
